// File: rtl/uart_tx_arbiter_if.sv
// Producer/transmitter handshake bundle for the UART TX arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
) ();

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_data;
  logic [12:0]        tx_clks_per_bit;
  logic               tx_run_n;
  logic               tx_done;

  // Arbiter side: consumes requests and transmitter status, drives accept and TX controls.
  modport master (
    input  req_valid,
    input  req_data,
    input  tx_done,
    output req_ready,
    output tx_data,
    output tx_clks_per_bit,
    output tx_run_n
  );

  // Producer/transmitter side: the mirror view.
  modport slave (
    output req_valid,
    output req_data,
    output tx_done,
    input  req_ready,
    input  tx_data,
    input  tx_clks_per_bit,
    input  tx_run_n
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between N_REQ byte producers,
// with per-frame watchdog and sticky timeout flag.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned GAP_CYC = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  uart_tx_arbiter_if.master     bus,
  input  logic [12:0]           cfg_clks_per_bit,
  input  logic                  err_clr,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic                  frame_done,
  output logic                  timeout_err
);

  localparam int unsigned CPB_W = 13;
  localparam int unsigned WD_W  = 17;
  localparam int unsigned GAP_W = 4;

  localparam logic [CPB_W-1:0] CPB_MIN  = CPB_W'(2);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [IDW-1:0]   GID_RST  = IDW'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [WD_W-1:0]  wd_cnt, wd_cnt_nxt;
  logic [WD_W-1:0]  wd_limit, wd_limit_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;

  logic             run_n_nxt;
  logic [N_REQ-1:0] ready_nxt;
  logic [7:0]       data_nxt;
  logic [CPB_W-1:0] cpb_nxt;
  logic [IDW-1:0]   gid_nxt;
  logic             busy_nxt;
  logic             fd_nxt;
  logic             err_nxt;
  logic             timeout_hit;

  logic             any_valid;
  logic [IDW-1:0]   win;
  logic [CPB_W-1:0] cpb_eff;

  // Round-robin pick: first valid requester after the last grant, wrapping.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win       = grant_id;
    any_valid = |bus.req_valid;
    // Descending scan so the smallest offset is the final (winning) assignment.
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      cand = 32'(grant_id) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (bus.req_valid[IDW'(cand)]) begin
        win = IDW'(cand);
      end
    end
  end

  // Divisor clamp: the transmitter needs at least two clocks per bit.
  always_comb begin
    cpb_eff = (cfg_clks_per_bit < CPB_MIN) ? CPB_MIN : cfg_clks_per_bit;
  end

  // Next-state and registered-output values.
  always_comb begin
    state_nxt    = state;
    run_n_nxt    = 1'b1;
    ready_nxt    = '0;
    fd_nxt       = 1'b0;
    data_nxt     = bus.tx_data;
    cpb_nxt      = bus.tx_clks_per_bit;
    gid_nxt      = grant_id;
    wd_limit_nxt = wd_limit;
    wd_cnt_nxt   = wd_cnt;
    gap_cnt_nxt  = gap_cnt;
    timeout_hit  = 1'b0;

    case (state)
      IDLE: begin
        if (any_valid) begin
          state_nxt    = LAUNCH;
          gid_nxt      = win;
          data_nxt     = bus.req_data[{win, 3'b000} +: 8];
          cpb_nxt      = cpb_eff;
          wd_limit_nxt = WD_W'(cpb_eff) * WD_W'(11) + WD_W'(16);
          run_n_nxt    = 1'b0;
          ready_nxt    = N_REQ'(1) << win;
        end
      end
      LAUNCH: begin
        state_nxt  = WAIT_DONE;
        wd_cnt_nxt = '0;
      end
      WAIT_DONE: begin
        if (bus.tx_done) begin
          fd_nxt      = 1'b1;
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
        end else if (wd_cnt == wd_limit) begin
          timeout_hit = 1'b1;
          state_nxt   = GAP;
          gap_cnt_nxt = '0;
        end else begin
          wd_cnt_nxt = wd_cnt + WD_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A timeout in the same cycle as err_clr keeps the flag set.
    if (timeout_hit) begin
      err_nxt = 1'b1;
    end else if (err_clr) begin
      err_nxt = 1'b0;
    end else begin
      err_nxt = timeout_err;
    end

    busy_nxt = (state_nxt != IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.tx_run_n        <= 1'b1;
      bus.req_ready       <= '0;
      bus.tx_data         <= '0;
      bus.tx_clks_per_bit <= CPB_MIN;
      grant_id            <= GID_RST;
      busy                <= 1'b0;
      frame_done          <= 1'b0;
      timeout_err         <= 1'b0;
      wd_cnt              <= '0;
      wd_limit            <= '0;
      gap_cnt             <= '0;
    end else begin
      bus.tx_run_n        <= run_n_nxt;
      bus.req_ready       <= ready_nxt;
      bus.tx_data         <= data_nxt;
      bus.tx_clks_per_bit <= cpb_nxt;
      grant_id            <= gid_nxt;
      busy                <= busy_nxt;
      frame_done          <= fd_nxt;
      timeout_err         <= err_nxt;
      wd_cnt              <= wd_cnt_nxt;
      wd_limit            <= wd_limit_nxt;
      gap_cnt             <= gap_cnt_nxt;
    end
  end

endmodule
